// File: rtl/mfp_input_conditioner.sv
// mfp_input_conditioner
//   Synchronises, debounces and edge-detects the asynchronous DE2-115 board
//   inputs (SW[17:0] on bits [17:0], KEY[3:0] on bits [21:18]) ahead of
//   mipsfpga_sys.
//
//   Parameters
//     WIDTH        number of conditioned inputs
//     TICK_DIV     clock cycles per sample tick (>= 2)
//     STABLE_TICKS consecutive mismatching ticks before db_out moves (>= 1)
//     INIT         reset value of synchronisers and db_out
//
//   Ports
//     SI_ClkIn    clock, rising edge
//     SI_Reset_N  asynchronous active-low reset
//     raw_in      asynchronous board inputs
//     db_out      debounced level (registered)
//     rise_pulse  one-cycle pulse aligned with a db_out 0->1 update
//     fall_pulse  one-cycle pulse aligned with a db_out 1->0 update
//     any_change  OR of all pulses, registered alongside them

package mfp_input_conditioner_pkg;
  // Registered per-lane response
  typedef struct packed {
    logic db;
    logic rise;
    logic fall;
  } lane_rsp_t;
endpackage

// mfp_ic_lane
//   One conditioned input: 2-flop synchroniser, qualification counter and
//   edge pulse generation.
//   Ports: clk/rst_n, shared tick, raw bit in, registered rsp, and fire
//   (combinational: db updates on this edge) for the shared any_change flop.
module mfp_ic_lane
  import mfp_input_conditioner_pkg::*;
#(
  parameter int   STABLE_TICKS = 10,
  parameter logic INIT_VAL     = 1'b0
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      tick,
  input  logic      raw,
  output lane_rsp_t rsp,
  output logic      fire
);
  localparam int CW = $clog2(STABLE_TICKS + 1);

  logic          s1, s2, db, rise, fall;
  logic [CW-1:0] cnt;
  logic          mismatch;

  assign mismatch = s2 ^ db;
  // Last qualifying tick: db takes s2 on this edge.
  assign fire     = mismatch & tick & (cnt == CW'(STABLE_TICKS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= INIT_VAL;
      s2   <= INIT_VAL;
      db   <= INIT_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
      cnt  <= '0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      rise <= 1'b0;
      fall <= 1'b0;
      // Any cycle back at the current level restarts qualification, even
      // between ticks, so short bounces never accumulate.
      if (!mismatch) begin
        cnt <= '0;
      end else if (tick) begin
        if (fire) begin
          db   <= s2;
          cnt  <= '0;
          rise <= s2;
          fall <= ~s2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign rsp.db   = db;
  assign rsp.rise = rise;
  assign rsp.fall = fall;
endmodule

module mfp_input_conditioner
  import mfp_input_conditioner_pkg::*;
#(
  parameter int               WIDTH        = 22,
  parameter int               TICK_DIV     = 50000,
  parameter int               STABLE_TICKS = 10,
  parameter logic [WIDTH-1:0] INIT         = {4'hF, 18'h0}
) (
  input  logic             SI_ClkIn,
  input  logic             SI_Reset_N,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] db_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             any_change
);
  localparam int TW = $clog2(TICK_DIV);

  logic [TW-1:0]    tcnt;
  logic             tick;
  lane_rsp_t [WIDTH-1:0] rsp;
  logic [WIDTH-1:0] fire;

  // Shared sample tick, one cycle in every TICK_DIV.
  assign tick = (tcnt == TW'(TICK_DIV - 1));

  always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
    if (!SI_Reset_N) tcnt <= '0;
    else             tcnt <= tick ? '0 : tcnt + 1'b1;
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    mfp_ic_lane #(
      .STABLE_TICKS (STABLE_TICKS),
      .INIT_VAL     (INIT[g])
    ) u_lane (
      .clk   (SI_ClkIn),
      .rst_n (SI_Reset_N),
      .tick  (tick),
      .raw   (raw_in[g]),
      .rsp   (rsp[g]),
      .fire  (fire[g])
    );
    assign db_out[g]     = rsp[g].db;
    assign rise_pulse[g] = rsp[g].rise;
    assign fall_pulse[g] = rsp[g].fall;
  end

  // Registered from the lanes' update strobes so it lands with the pulses.
  always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
    if (!SI_Reset_N) any_change <= 1'b0;
    else             any_change <= |fire;
  end
endmodule
